shared_timer_sched: RTL and testbench



---
 rtl/shared_timer_sched.sv | 135 +++++++++++++
 tb/tb_shared_timer_sched.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/shared_timer_sched.sv
// Round-robin scheduler sharing one down-counting interval timer between NREQ requesters.
// Optional pause input is enabled by defining TIMER_PAUSE_EN.
module shared_timer_sched #(
    parameter int CNT_W = 8,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CNT_W-1:0] req_len,
    input  logic                  abort,
`ifdef TIMER_PAUSE_EN
    input  logic                  pause,
`endif
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [CNT_W-1:0]      count
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;

    logic               found;
    logic [PTR_W-1:0]   winner;
    logic [CNT_W-1:0]   win_len;
    logic               run_hold;

`ifdef TIMER_PAUSE_EN
    assign run_hold = pause;
`else
    assign run_hold = 1'b0;
`endif

    // Search upward from the slot after the last grant, wrapping, so every
    // pending requester is served once before anyone is granted again.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = ptr_q;
        for (int i = 1; i <= NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[PTR_W'(idx)]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        win_len = req_len[int'(winner)*CNT_W +: CNT_W];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            owner_q <= '0;
            ptr_q   <= PTR_W'(NREQ - 1);
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Abort wins over both pause and the final-count transition.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                count_d = '0;
                if (found) begin
                    state_d = RUN;
                    owner_d = winner;
                    ptr_d   = winner;
                    count_d = (win_len == '0) ? CNT_W'(1) : win_len;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (run_hold) begin
                    count_d = count_q;
                end else if (count_q <= CNT_W'(1)) begin
                    state_d = DONE;
                    count_d = '0;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                count_d = '0;
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_comb begin
        grant = '0;
        done  = '0;
        if (state_q == RUN) begin
            grant = NREQ'(1) << owner_q;
        end
        if (state_q == DONE) begin
            done = NREQ'(1) << owner_q;
        end
    end

    assign busy  = (state_q == RUN) || (state_q == DONE);
    assign count = count_q;

endmodule

// File: tb/tb_shared_timer_sched.sv
// Table-driven bench for shared_timer_sched with a per-cycle expected-output scoreboard.
// Define TIMER_PAUSE_EN to also exercise the pause input.
module tb_shared_timer_sched;

    localparam int CNT_W = 8;
    localparam int NREQ  = 4;

    typedef struct {
        int          id;
        logic [3:0]  req;
        logic [31:0] len;
        logic        abort;
        logic        pause;
        logic [3:0]  g;
        logic [3:0]  d;
        logic        b;
        logic [7:0]  c;
    } vec_t;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*CNT_W-1:0] req_len;
    logic                  abort;
    logic                  pause;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic [CNT_W-1:0]      count;

    vec_t table_q[$];
    vec_t sb_q[$];
    int   vectors;
    int   miscompares;
    int   next_id;

    shared_timer_sched #(.CNT_W(CNT_W), .NREQ(NREQ)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .req_len (req_len),
        .abort   (abort),
`ifdef TIMER_PAUSE_EN
        .pause   (pause),
`endif
        .grant   (grant),
        .done    (done),
        .busy    (busy),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lens(input int l3, input int l2, input int l1, input int l0);
        return {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
    endfunction

    function automatic vec_t mk(input logic [3:0] r, input logic [31:0] l, input logic a,
                                input logic p, input logic [3:0] g, input logic [3:0] d,
                                input logic b, input int c);
        vec_t v;
        v.id = next_id; v.req = r; v.len = l; v.abort = a; v.pause = p;
        v.g = g; v.d = d; v.b = b; v.c = c[7:0];
        next_id++;
        return v;
    endfunction

    task automatic add(input logic [3:0] r, input logic [31:0] l, input logic a,
                       input logic [3:0] g, input logic [3:0] d, input logic b, input int c);
        table_q.push_back(mk(r, l, a, 1'b0, g, d, b, c));
    endtask

    task automatic checkOutput();
        vec_t e;
        if (sb_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        e = sb_q.pop_front();
        vectors++;
        if (grant !== e.g || done !== e.d || busy !== e.b || count !== e.c) begin
            miscompares++;
            $display("[TB] FAIL vec%0d: got grant=%b done=%b busy=%b count=%0d, want grant=%b done=%b busy=%b count=%0d",
                     e.id, grant, done, busy, count, e.g, e.d, e.b, e.c);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req     = v.req;
        req_len = v.len;
        abort   = v.abort;
        pause   = v.pause;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        req = '0; abort = 1'b0; pause = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        sb_q.push_back(mk(4'b0000, 32'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 0));
        checkOutput();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0; next_id = 0;
        req = '0; req_len = '0; abort = 1'b0; pause = 1'b0;
        reset = 1'b1;
        #12;
        sb_q.push_back(mk(4'b0000, 32'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 0));
        checkOutput();
        @(negedge clk);
        reset = 1'b0;

        // Two requesters held, alternating service starting at requester 0
        for (int k = 0; k < 2; k++) begin
            add(4'b0101, lens(0, 2, 0, 2), 0, 4'b0001, 4'b0000, 1, 2);
            add(4'b0101, lens(0, 2, 0, 2), 0, 4'b0001, 4'b0000, 1, 1);
            add(4'b0101, lens(0, 2, 0, 2), 0, 4'b0000, 4'b0001, 1, 0);
            add(4'b0101, lens(0, 2, 0, 2), 0, 4'b0000, 4'b0000, 0, 0);
            add(4'b0101, lens(0, 2, 0, 2), 0, 4'b0100, 4'b0000, 1, 2);
            add(4'b0101, lens(0, 2, 0, 2), 0, 4'b0100, 4'b0000, 1, 1);
            add(4'b0101, lens(0, 2, 0, 2), 0, 4'b0000, 4'b0100, 1, 0);
            add(4'b0101, lens(0, 2, 0, 2), 0, 4'b0000, 4'b0000, 0, 0);
        end
        // Single job of length 3; abort in IDLE is ignored
        add(4'b0001, lens(0, 0, 0, 3), 1, 4'b0001, 4'b0000, 1, 3);
        add(4'b0000, lens(0, 0, 0, 3), 0, 4'b0001, 4'b0000, 1, 2);
        add(4'b0000, lens(0, 0, 0, 3), 0, 4'b0001, 4'b0000, 1, 1);
        add(4'b0000, lens(0, 0, 0, 3), 0, 4'b0000, 4'b0001, 1, 0);
        add(4'b0000, lens(0, 0, 0, 3), 0, 4'b0000, 4'b0000, 0, 0);
        // Zero length runs for one cycle
        add(4'b0010, lens(0, 0, 0, 0), 0, 4'b0010, 4'b0000, 1, 1);
        add(4'b0000, lens(0, 0, 0, 0), 0, 4'b0000, 4'b0010, 1, 0);
        add(4'b0000, lens(0, 0, 0, 0), 0, 4'b0000, 4'b0000, 0, 0);
        // Abort at count 6, then pending requester 0 is served
        add(4'b1000, lens(10, 0, 0, 2), 0, 4'b1000, 4'b0000, 1, 10);
        add(4'b0001, lens(10, 0, 0, 2), 0, 4'b1000, 4'b0000, 1, 9);
        add(4'b0001, lens(10, 0, 0, 2), 0, 4'b1000, 4'b0000, 1, 8);
        add(4'b0001, lens(10, 0, 0, 2), 0, 4'b1000, 4'b0000, 1, 7);
        add(4'b0001, lens(10, 0, 0, 2), 0, 4'b1000, 4'b0000, 1, 6);
        add(4'b0001, lens(10, 0, 0, 2), 1, 4'b0000, 4'b0000, 0, 0);
        add(4'b0001, lens(10, 0, 0, 2), 0, 4'b0001, 4'b0000, 1, 2);
        add(4'b0000, lens(10, 0, 0, 2), 0, 4'b0001, 4'b0000, 1, 1);
        add(4'b0000, lens(10, 0, 0, 2), 0, 4'b0000, 4'b0001, 1, 0);
        add(4'b0000, lens(10, 0, 0, 2), 0, 4'b0000, 4'b0000, 0, 0);
        // Abort beats the final-count transition: no done pulse
        add(4'b0100, lens(0, 1, 0, 0), 0, 4'b0100, 4'b0000, 1, 1);
        add(4'b0000, lens(0, 1, 0, 0), 1, 4'b0000, 4'b0000, 0, 0);
        add(4'b0000, lens(0, 1, 0, 0), 0, 4'b0000, 4'b0000, 0, 0);

        for (int i = 0; i < table_q.size(); i++) begin
            applyStimulus(table_q[i]);
        end

        // Asynchronous reset in the middle of a run
        applyStimulus(mk(4'b1000, lens(6, 0, 0, 0), 0, 0, 4'b1000, 4'b0000, 1, 6));
        applyStimulus(mk(4'b0000, lens(6, 0, 0, 0), 0, 0, 4'b1000, 4'b0000, 1, 5));
        applyStimulus(mk(4'b0000, lens(6, 0, 0, 0), 0, 0, 4'b1000, 4'b0000, 1, 4));
        #2;
        reset = 1'b1;
        #1;
        sb_q.push_back(mk(4'b0000, 32'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 0));
        checkOutput();
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(mk(4'b1001, lens(5, 0, 0, 2), 0, 0, 4'b0001, 4'b0000, 1, 2));
        applyStimulus(mk(4'b0000, lens(5, 0, 0, 2), 0, 0, 4'b0001, 4'b0000, 1, 1));
        applyStimulus(mk(4'b0000, lens(5, 0, 0, 2), 0, 0, 4'b0000, 4'b0001, 1, 0));
        applyStimulus(mk(4'b0000, lens(5, 0, 0, 2), 0, 0, 4'b0000, 4'b0000, 0, 0));

`ifdef TIMER_PAUSE_EN
        // Pause holds count at 2 for three cycles, stretching grant to 7 cycles
        doReset();
        applyStimulus(mk(4'b0001, lens(0, 0, 0, 4), 0, 0, 4'b0001, 4'b0000, 1, 4));
        applyStimulus(mk(4'b0000, lens(0, 0, 0, 4), 0, 0, 4'b0001, 4'b0000, 1, 3));
        applyStimulus(mk(4'b0000, lens(0, 0, 0, 4), 0, 0, 4'b0001, 4'b0000, 1, 2));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mk(4'b0000, lens(0, 0, 0, 4), 0, 1, 4'b0001, 4'b0000, 1, 2));
        end
        applyStimulus(mk(4'b0000, lens(0, 0, 0, 4), 0, 0, 4'b0001, 4'b0000, 1, 1));
        applyStimulus(mk(4'b0000, lens(0, 0, 0, 4), 0, 0, 4'b0000, 4'b0001, 1, 0));
        applyStimulus(mk(4'b0000, lens(0, 0, 0, 4), 0, 0, 4'b0000, 4'b0000, 0, 0));
        // Abort while paused still cancels
        applyStimulus(mk(4'b0010, lens(0, 0, 5, 0), 0, 1, 4'b0010, 4'b0000, 1, 5));
        applyStimulus(mk(4'b0000, lens(0, 0, 5, 0), 1, 1, 4'b0000, 4'b0000, 0, 0));
`else
        doReset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
